// File: rtl/conv2d_stream_pkg.sv
// conv2d_stream shared types and helpers.
// Holds the FSM state type, output-size math and saturation.
package conv2d_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    FINAL,
    OUTPUT
  } state_t;

  function automatic int out_dim(
    input int n,
    input int k,
    input int p,
    input int s
  );
    return (n + 2 * p - k) / s + 1;
  endfunction

  function automatic int aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int bits
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv2d_stream_mac.sv
// conv2d_stream MAC and requantise datapath.
// Define CONV2D_STREAM_RELU_EN to clamp negative results to zero.
module conv2d_stream_mac
  import conv2d_stream_pkg::*;
#(
  parameter int ACTIV_BITS = 8,
  parameter int ACC_BITS   = 24,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clr,
  input  logic                         i_en,
  input  logic signed [ACTIV_BITS-1:0] i_act,
  input  logic signed [ACTIV_BITS-1:0] i_wt,
  input  logic signed [ACTIV_BITS-1:0] i_bias,
  output logic signed [ACTIV_BITS-1:0] o_res
);

  localparam int PW = 2 * ACTIV_BITS;

  logic signed [PW-1:0]       r_prod;
  logic                       r_pv;
  logic signed [ACC_BITS-1:0] r_acc;
  logic signed [63:0]         w_ext;
  logic signed [ACTIV_BITS-1:0] w_sat;

  // product is registered; accumulate lags it by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_pv   <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_prod <= i_act * i_wt;
      r_pv   <= i_en && !i_clr;
      if (i_clr)
        r_acc <= {{(ACC_BITS-ACTIV_BITS){i_bias[ACTIV_BITS-1]}},
                  i_bias};
      else if (r_pv)
        r_acc <= r_acc + {{(ACC_BITS-PW){r_prod[PW-1]}}, r_prod};
    end
  end

  assign w_ext = {{(64-ACC_BITS){r_acc[ACC_BITS-1]}}, r_acc};
  assign w_sat = ACTIV_BITS'(sat(w_ext >>> OUT_SHIFT, ACTIV_BITS));

`ifdef CONV2D_STREAM_RELU_EN
  assign o_res = w_sat[ACTIV_BITS-1] ? '0 : w_sat;
`else
  assign o_res = w_sat;
`endif

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: frame-buffered streaming 2D convolution.
// Optional ReLU via CONV2D_STREAM_RELU_EN (see conv2d_stream_mac).
module conv2d_stream
  import conv2d_stream_pkg::*;
#(
  parameter int IN_W        = 40,
  parameter int IN_H        = 1,
  parameter int IN_CH       = 1,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_FILTERS = 8,
  parameter int PADDING     = 1,
  parameter int STRIDE      = 1,
  parameter int ACTIV_BITS  = 8,
  parameter int ACC_BITS    = 24,
  parameter int OUT_SHIFT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACTIV_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACTIV_BITS-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  input  logic                  w_wr_en,
  input  logic [aw(NUM_FILTERS*IN_CH*KERNEL_SIZE*KERNEL_SIZE)-1:0]
                                w_wr_addr,
  input  logic [ACTIV_BITS-1:0] w_wr_data,
  input  logic                  b_wr_en,
  input  logic [aw(NUM_FILTERS)-1:0] b_wr_addr,
  input  logic [ACTIV_BITS-1:0] b_wr_data,
  output logic                  busy
);

  localparam int OUT_W = out_dim(IN_W, KERNEL_SIZE, PADDING, STRIDE);
  localparam int OUT_H = out_dim(IN_H, KERNEL_SIZE, PADDING, STRIDE);
  localparam int TAPS  = IN_CH * KERNEL_SIZE * KERNEL_SIZE;
  localparam int NPIX  = IN_W * IN_H * IN_CH;
  localparam int NW    = NUM_FILTERS * TAPS;
  localparam int WAW   = aw(NW);
  localparam int BAW   = aw(NUM_FILTERS);
  localparam int PAW   = aw(NPIX);
  localparam int KW    = aw(KERNEL_SIZE);
  localparam int CHW   = aw(IN_CH);
  localparam int OWW   = aw(OUT_W);
  localparam int OHW   = aw(OUT_H);

  state_t r_state, w_nstate;

  logic                  r_rdy, r_drain;
  logic                  r_out_valid, r_out_last;
  logic [ACTIV_BITS-1:0] r_out_data;
  logic [PAW-1:0]        r_in_cnt;
  logic [KW-1:0]         r_kx, r_ky;
  logic [CHW-1:0]        r_c;
  logic [BAW-1:0]        r_f, w_nf;
  logic [OWW-1:0]        r_ow;
  logic [OHW-1:0]        r_oh;

  logic [ACTIV_BITS-1:0] r_buf  [NPIX];
  logic [ACTIV_BITS-1:0] r_wt   [NW];
  logic [ACTIV_BITS-1:0] r_bias [NUM_FILTERS];

  logic w_xfer, w_last_in, w_last_tap;
  logic w_last_f, w_last_ow, w_last_oh;
  logic w_acc_out, w_clr, w_en, w_inb;
  int   w_iy, w_ix;
  logic [PAW-1:0]        w_pa;
  logic [WAW-1:0]        w_wa;
  logic [ACTIV_BITS-1:0] w_act, w_wt, w_bias, w_res;

  assign w_xfer     = in_valid && r_rdy;
  assign w_last_in  = r_in_cnt == PAW'(NPIX - 1);
  assign w_last_tap = (r_kx == KW'(KERNEL_SIZE - 1)) &&
                      (r_ky == KW'(KERNEL_SIZE - 1)) &&
                      (r_c == CHW'(IN_CH - 1));
  assign w_last_f   = r_f == BAW'(NUM_FILTERS - 1);
  assign w_last_ow  = r_ow == OWW'(OUT_W - 1);
  assign w_last_oh  = r_oh == OHW'(OUT_H - 1);
  assign w_acc_out  = (r_state == OUTPUT) && out_ready;
  assign w_clr      = (w_nstate == COMPUTE) && (r_state != COMPUTE);
  assign w_en       = (r_state == COMPUTE) && !r_drain;

  // bias is fetched for the filter the coming COMPUTE will produce
  always_comb begin
    w_nf = r_f;
    if (r_state == OUTPUT)
      w_nf = w_last_f ? '0 : r_f + BAW'(1);
  end

  always_comb begin
    w_iy  = int'(r_oh) * STRIDE + int'(r_ky) - PADDING;
    w_ix  = int'(r_ow) * STRIDE + int'(r_kx) - PADDING;
    w_inb = (w_iy >= 0) && (w_iy < IN_H) &&
            (w_ix >= 0) && (w_ix < IN_W);
    w_pa  = '0;
    if (w_inb)
      w_pa = PAW'((w_iy * IN_W + w_ix) * IN_CH + int'(r_c));
    w_act = w_inb ? r_buf[w_pa] : '0;
    w_wa  = WAW'(((int'(r_f) * IN_CH + int'(r_c)) * KERNEL_SIZE
                 + int'(r_ky)) * KERNEL_SIZE + int'(r_kx));
  end

  assign w_wt   = r_wt[w_wa];
  assign w_bias = r_bias[w_nf];

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE:    if (w_xfer) w_nstate = w_last_in ? COMPUTE : LOAD;
      LOAD:    if (w_xfer && w_last_in) w_nstate = COMPUTE;
      COMPUTE: if (r_drain) w_nstate = FINAL;
      FINAL:   w_nstate = OUTPUT;
      OUTPUT:  if (out_ready) w_nstate = r_out_last ? IDLE : COMPUTE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_rdy   <= (w_nstate == IDLE) || (w_nstate == LOAD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_cnt    <= '0;
      r_kx        <= '0;
      r_ky        <= '0;
      r_c         <= '0;
      r_drain     <= 1'b0;
      r_f         <= '0;
      r_ow        <= '0;
      r_oh        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < NPIX; i++) r_buf[i] <= '0;
      for (int i = 0; i < NW; i++) r_wt[i] <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) r_bias[i] <= '0;
    end else begin
      if (w_xfer) begin
        r_buf[r_in_cnt] <= in_data;
        r_in_cnt <= w_last_in ? '0 : r_in_cnt + PAW'(1);
      end
      if (w_wr_en && (r_state == IDLE) && (int'(w_wr_addr) < NW))
        r_wt[w_wr_addr] <= w_wr_data;
      if (b_wr_en && (r_state == IDLE) &&
          (int'(b_wr_addr) < NUM_FILTERS))
        r_bias[b_wr_addr] <= b_wr_data;
      if (w_clr) begin
        r_kx    <= '0;
        r_ky    <= '0;
        r_c     <= '0;
        r_drain <= 1'b0;
      end else if (w_en) begin
        if (w_last_tap) r_drain <= 1'b1;
        if (r_kx != KW'(KERNEL_SIZE - 1)) begin
          r_kx <= r_kx + KW'(1);
        end else begin
          r_kx <= '0;
          if (r_ky != KW'(KERNEL_SIZE - 1)) begin
            r_ky <= r_ky + KW'(1);
          end else begin
            r_ky <= '0;
            r_c  <= (r_c == CHW'(IN_CH - 1)) ? '0 : r_c + CHW'(1);
          end
        end
      end
      if (r_state == FINAL) begin
        r_out_data  <= w_res;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_f && w_last_ow && w_last_oh;
      end else if (w_acc_out) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_f         <= w_nf;
        if (w_last_f) begin
          r_ow <= w_last_ow ? '0 : r_ow + OWW'(1);
          if (w_last_ow)
            r_oh <= w_last_oh ? '0 : r_oh + OHW'(1);
        end
      end
    end
  end

  conv2d_stream_mac #(
    .ACTIV_BITS(ACTIV_BITS),
    .ACC_BITS  (ACC_BITS),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_act (w_act),
    .i_wt  (w_wt),
    .i_bias(w_bias),
    .o_res (w_res)
  );

  assign in_ready  = r_rdy;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_state != IDLE;

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream (4x1 input, 3x3 kernel).
// Two DUTs share stimulus: u_a (STRIDE=1) and u_b (STRIDE=2).
module tb_conv2d_stream;

  typedef int v4_t[4];
  typedef int k9_t[9];

`ifdef CONV2D_STREAM_RELU_EN
  localparam int NEGX = 0;
`else
  localparam int NEGX = -128;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       w_wr_en = 1'b0;
  logic [3:0] w_wr_addr = '0;
  logic [7:0] w_wr_data = '0;
  logic       b_wr_en = 1'b0;
  logic [0:0] b_wr_addr = '0;
  logic [7:0] b_wr_data = '0;

  logic [7:0] a_data, b_data, m_data;
  logic a_valid, b_valid, a_last, b_last, a_rdy, b_rdy;
  logic a_busy, b_busy;
  logic m_valid, m_last, m_rdy, m_busy;
  logic sel = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  k9_t kid, kon, ksat, kz;
  v4_t dinc, dpos, dneg, e;

  always #5 clk = ~clk;

  conv2d_stream #(
    .IN_W(4), .IN_H(1), .IN_CH(1), .KERNEL_SIZE(3),
    .NUM_FILTERS(1), .PADDING(1), .STRIDE(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_rdy),
    .out_data(a_data), .out_valid(a_valid),
    .out_ready(out_ready), .out_last(a_last),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr),
    .b_wr_data(b_wr_data),
    .busy(a_busy)
  );

  conv2d_stream #(
    .IN_W(4), .IN_H(1), .IN_CH(1), .KERNEL_SIZE(3),
    .NUM_FILTERS(1), .PADDING(1), .STRIDE(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_rdy),
    .out_data(b_data), .out_valid(b_valid),
    .out_ready(out_ready), .out_last(b_last),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr),
    .b_wr_data(b_wr_data),
    .busy(b_busy)
  );

  assign m_data  = sel ? b_data : a_data;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_last  = sel ? b_last : a_last;
  assign m_rdy   = sel ? b_rdy : a_rdy;
  assign m_busy  = sel ? b_busy : a_busy;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, int'(m_valid), 0);
    chk({tag, "_data"}, int'(m_data), 0);
    chk({tag, "_last"}, int'(m_last), 0);
    chk({tag, "_rdy"}, int'(m_rdy), 0);
    chk({tag, "_busy"}, int'(m_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy_rel"}, int'(m_rdy), 1);
  endtask

  task automatic load_w(input k9_t k, input int b);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      w_wr_en = 1'b1;
      w_wr_addr = 4'(i);
      w_wr_data = k[i][7:0];
    end
    @(negedge clk);
    w_wr_en = 1'b0;
    b_wr_en = 1'b1;
    b_wr_addr = '0;
    b_wr_data = b[7:0];
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic send(input v4_t din);
    int i = 0;
    int cyc = 0;
    while (i < 4 && cyc < 200) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = din[i][7:0];
      cyc++;
      if (m_rdy) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("send_done", i, 4);
  endtask

  task automatic run_frame(input string tag, input v4_t din,
                           input v4_t ex, input int n,
                           input int hold_idx);
    int lat, k, cyc, bad, nx;
    logic [7:0] d0;
    logic l0;
    send(din);
    lat = 0;
    while (!m_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 11);
    k = 0;
    cyc = 0;
    while (k < n && cyc < 1000) begin
      if (m_valid) begin
        if (k == hold_idx) begin
          out_ready = 1'b0;
          d0 = m_data;
          l0 = m_last;
          bad = 0;
          repeat (10) begin
            @(negedge clk);
            if (!m_valid || m_data != d0 || m_last != l0 || m_rdy)
              bad++;
          end
          chk({tag, "_hold_stable"}, bad, 0);
          out_ready = 1'b1;
        end
        chk($sformatf("%s_data%0d", tag, k), int'($signed(m_data)),
            ex[k]);
        chk($sformatf("%s_last%0d", tag, k), int'(m_last),
            (k == n - 1) ? 1 : 0);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_count"}, k, n);
    nx = 0;
    repeat (15) begin
      if (m_valid) nx++;
      @(negedge clk);
    end
    chk({tag, "_no_extra"}, nx, 0);
    chk({tag, "_busy_end"}, int'(m_busy), 0);
    cyc = 0;
    while ((a_busy || b_busy) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_idle"}, int'(a_busy || b_busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nq;
    kid  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    kon  = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    ksat = '{0, 0, 0, 0, 127, 0, 0, 0, 0};
    kz   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    dinc = '{1, 2, 3, 4};
    dpos = '{127, 127, 127, 127};
    dneg = '{-128, -128, -128, -128};
    repeat (2) @(negedge clk);
    do_reset("init");

    load_w(kid, 0);
    e = '{1, 2, 3, 4};
    run_frame("ident", dinc, e, 4, -1);

    load_w(kon, 0);
    e = '{3, 6, 9, 7};
    run_frame("ones", dinc, e, 4, -1);

    load_w(kon, -2);
    e = '{1, 4, 7, 5};
    run_frame("bias", dinc, e, 4, -1);

    load_w(ksat, 0);
    e = '{127, 127, 127, 127};
    run_frame("satp", dpos, e, 4, -1);
    e = '{NEGX, NEGX, NEGX, NEGX};
    run_frame("satn", dneg, e, 4, -1);

    load_w(kid, 0);
    e = '{1, 2, 3, 4};
    run_frame("hold", dinc, e, 4, 1);

    sel = 1'b1;
    e = '{1, 3, 0, 0};
    run_frame("stride", dinc, e, 2, -1);
    sel = 1'b0;

    send(dinc);
    repeat (3) @(negedge clk);
    do_reset("abort");
    nq = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_valid || b_valid) nq++;
    end
    chk("abort_quiet", nq, 0);

    e = '{0, 0, 0, 0};
    run_frame("wclr", dinc, e, 4, -1);

    load_w(kz, 0);
    load_w(kid, 0);
    e = '{1, 2, 3, 4};
    run_frame("reload", dinc, e, 4, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 SHALL have parameter IN_W, default 40, input width.
REQ-002 SHALL have parameter IN_H, default 1, input height.
REQ-003 SHALL have parameter IN_CH, default 1, input channels.
REQ-004 SHALL have parameter KERNEL_SIZE, default 3, square kernel side.
REQ-005 SHALL have parameter NUM_FILTERS, default 8, output channels.
REQ-006 SHALL have parameters PADDING (default 1), STRIDE (default 1), ACTIV_BITS (default 8), ACC_BITS (default 24), OUT_SHIFT (default 0).
REQ-007 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-008 SHALL have ports in_data (input, ACTIV_BITS, signed activation), in_valid (input, 1), in_ready (output, 1).
REQ-009 SHALL have ports out_data (output, ACTIV_BITS, signed result), out_valid (output, 1), out_ready (input, 1), out_last (output, 1, final element of frame).
REQ-010 SHALL have ports w_wr_en (input, 1), w_wr_addr (input, clog2(NUM_FILTERS*IN_CH*KERNEL_SIZE^2)), w_wr_data (input, ACTIV_BITS), b_wr_en (input, 1), b_wr_addr (input, clog2(NUM_FILTERS)), b_wr_data (input, ACTIV_BITS).
REQ-011 SHALL have port busy (output, 1), high whenever the state is not IDLE.

Function
REQ-012 SHALL derive OUT_W=(IN_W+2*PADDING-KERNEL_SIZE)/STRIDE+1 and OUT_H likewise.
REQ-013 SHALL implement states IDLE, LOAD, COMPUTE, FINAL and OUTPUT.
REQ-014 IDLE SHALL move to LOAD on the first in_valid; in_ready SHALL be high only in IDLE and LOAD.
REQ-015 In LOAD, a transfer SHALL occur on in_valid&&in_ready, with raster order and channel fastest; after IN_W*IN_H*IN_CH transfers the block SHALL enter COMPUTE.
REQ-016 Weight address order SHALL be filter, channel, row, col, with col fastest; writes SHALL be accepted only in IDLE and ignored otherwise.
REQ-017 Output order SHALL be oh, ow, filter, with filter fastest.
REQ-018 COMPUTE SHALL perform one signed MAC per cycle over IN_CH*KERNEL_SIZE^2 taps; out-of-bounds (padding) taps SHALL contribute zero but still consume a cycle.
REQ-019 The accumulator SHALL be signed ACC_BITS and initialised to the sign-extended bias.
REQ-020 FINAL SHALL arithmetic-shift right by OUT_SHIFT, saturate to [-2^(ACTIV_BITS-1), 2^(ACTIV_BITS-1)-1], and register out_data with out_valid=1.
REQ-021 out_valid SHALL rise exactly IN_CH*KERNEL_SIZE^2+2 cycles after the edge accepting the last input.
REQ-022 In OUTPUT, out_data, out_valid and out_last SHALL stay stable until out_ready; on acceptance the block SHALL go to COMPUTE for the next output, or to IDLE after the last.
REQ-023 out_last SHALL be high only with the final output (oh=OUT_H-1, ow=OUT_W-1, f=NUM_FILTERS-1).
REQ-024 in_valid in COMPUTE, FINAL or OUTPUT SHALL be ignored.

Reset
REQ-025 On rst_n=0 at a clock edge: state=IDLE; out_data=0; out_valid=0; out_last=0; in_ready=0; busy=0; all counters, accumulator, input buffer, weights and biases=0.
REQ-026 A reset in any state, including mid-COMPUTE or mid-OUTPUT, SHALL abort the frame with no further output.
REQ-027 in_ready SHALL be 1 from the first cycle after reset is released.

Configuration
REQ-028 With macro CONV2D_STREAM_RELU_EN defined, FINAL SHALL clamp negative saturated results to 0.
REQ-029 Without CONV2D_STREAM_RELU_EN, signed saturated results SHALL pass unchanged.

Structure
REQ-030 Package conv2d_stream_pkg SHALL hold the state enum, the OUT_W/OUT_H computation functions, and the saturate function.
REQ-031 The MAC and requantise datapath SHALL be the sub-module conv2d_stream_mac (accumulate, clear-with-bias, shift/saturate/ReLU); the FSM, counters and buffers SHALL stay in the top.

Verification
All scenarios use IN_W=4, IN_H=1, IN_CH=1, KERNEL_SIZE=3, NUM_FILTERS=1, PADDING=1, unless stated.
REQ-032 Identity kernel (centre weight 1), bias 0, input 1,2,3,4 -> outputs 1,2,3,4, out_last on 4.
REQ-033 All-ones kernel, bias 0, input 1,2,3,4 -> outputs 3,6,9,7; with bias -2 -> 1,4,7,5.
REQ-034 Centre weight 127, input 127 -> 127 (saturated); input -128 -> -128 without RELU_EN, 0 with RELU_EN.
REQ-035 out_ready held low 10 cycles -> out_data/out_valid stable, in_ready=0, no output lost or duplicated.
REQ-036 STRIDE=2, identity kernel, input 1,2,3,4 -> OUT_W=2, outputs 1,3.
REQ-037 rst_n low for 1 cycle mid-COMPUTE -> next cycle all outputs 0, busy=0, and a new frame processes correctly after weights are reloaded.
